// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Purpose:
//   Writer side of the instruction-memory interface. It takes a byte stream
//   (typically from a UART receiver) that starts with a 2-byte big-endian
//   word count N. N big-endian 32-bit words follow. The loader writes those
//   words to consecutive IMEM words, starting at word 0. While a load is in
//   progress it holds the CPU.
//
// Ports:
//   clk        in   system clock, rising edge
//   rstn       in   asynchronous active-low reset
//   start      in   one-cycle pulse that begins a load (ignored while busy)
//   rx_valid   in   rx_data holds a byte
//   rx_data    in   received byte
//   rx_ready   out  loader accepts a byte this cycle (transfer = valid & ready)
//   mem_we     out  IMEM write strobe, one cycle per word
//   mem_addr   out  IMEM byte address (word_index << 2)
//   mem_wdata  out  assembled word to write
//   busy       out  load in progress
//   cpu_hold   out  copy of busy; the CPU PC must not advance while high
//   done       out  sticky: last load finished, cleared by an accepted start
//   err        out  sticky: header count exceeded DEPTH, cleared by an accepted start
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int DEPTH = 128,
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_WRITE,
        S_DONE
    } state_t;

    // DEPTH is widened by one bit so that comparisons against counts up to
    // 2^CNT_W-1 stay unsigned and cannot overflow.
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W+1)'(DEPTH);

    state_t           state_q, state_d;
    logic [7:0]       n_hi_q, n_hi_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] index_q, index_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             xfer;
    logic [CNT_W-1:0] n_full;
    logic [CNT_W-1:0] index_inc;
    logic             in_range;

    assign xfer      = rx_valid & rx_ready;
    assign n_full    = CNT_W'({n_hi_q, rx_data});
    assign index_inc = index_q + CNT_W'(1);
    assign in_range  = ({1'b0, index_q} < DEPTH_L);

    always_comb begin
        state_d    = state_q;
        n_hi_d     = n_hi_q;
        cnt_d      = cnt_q;
        index_d    = index_q;
        byte_cnt_d = byte_cnt_q;
        wdata_d    = wdata_q;
        done_d     = done_q;
        err_d      = err_q;
        rx_ready   = 1'b0;
        mem_we     = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_LEN_HI;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    index_d    = '0;
                    byte_cnt_d = '0;
                end
            end
            S_LEN_HI: begin
                rx_ready = 1'b1;
                if (xfer) begin
                    n_hi_d  = rx_data;
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                rx_ready = 1'b1;
                if (xfer) begin
                    cnt_d = n_full;
                    if ({1'b0, n_full} > DEPTH_L) begin
                        err_d = 1'b1;
                    end
                    if (n_full == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                rx_ready = 1'b1;
                if (xfer) begin
                    wdata_d    = {wdata_q[23:0], rx_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                // Words beyond the end of memory are still consumed from the
                // stream so that the byte framing stays aligned. They are
                // simply not written.
                mem_we  = in_range;
                index_d = index_inc;
                if (index_inc == cnt_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_DATA;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            n_hi_q     <= '0;
            cnt_q      <= '0;
            index_q    <= '0;
            byte_cnt_q <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_hi_q     <= n_hi_d;
            cnt_q      <= cnt_d;
            index_q    <= index_d;
            byte_cnt_q <= byte_cnt_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign mem_addr  = {{(30-CNT_W){1'b0}}, index_q, 2'b00};
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign cpu_hold  = busy;
    assign done      = done_q;
    assign err       = err_q;

endmodule
